// File: rtl/router_input_ctrl_tdm_if.sv
// Handshake and status bundle between an input queue head and its
// router input controller.
interface router_input_ctrl_tdm_if #(
    parameter int c_dest_nbits = 3,
    parameter int c_dom_nbits  = 1
);
    logic [c_dest_nbits-1:0] dest;
    logic [c_dom_nbits-1:0]  in_domain;
    logic                    in_tail;
    logic                    in_val;
    logic                    in_rdy;
    logic [2:0]              reqs;
    logic [2:0]              grants;
    logic [c_dom_nbits-1:0]  slot_domain;
    logic                    locked;
    logic                    bad_dest;

    modport master (
        output dest, in_domain, in_tail, in_val, grants,
        input  in_rdy, reqs, slot_domain, locked, bad_dest
    );

    modport slave (
        input  dest, in_domain, in_tail, in_val, grants,
        output in_rdy, reqs, slot_domain, locked, bad_dest
    );
endinterface

// File: rtl/router_input_ctrl_tdm.sv
// Ring-router input controller: shortest-path routing, packet locking, TDM
// request gating. Define ROUTER_INPUT_CTRL_TDM_GUARD_EN for the slot-end guard band.
module router_input_ctrl_tdm #(
    parameter int         p_router_id   = 0,
    parameter int         p_num_routers = 8,
    parameter int         p_num_domains = 2,
    parameter int         p_slot_len    = 16,
    parameter logic [2:0] p_tie_reqs    = 3'b001,
    parameter int         p_guard       = 4,
    localparam int c_dest_nbits = $clog2(p_num_routers),
    localparam int c_dom_nbits  = (p_num_domains > 1) ? $clog2(p_num_domains) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    router_input_ctrl_tdm_if.slave io
);

    localparam int c_cnt_nbits = $clog2(p_slot_len);
    localparam int c_dw        = c_dest_nbits + 1;

    typedef logic [c_dw-1:0]        dist_t;
    typedef logic [c_cnt_nbits-1:0] cnt_t;
    typedef logic [c_dom_nbits-1:0] dom_t;

    localparam dist_t c_n           = dist_t'(p_num_routers);
    localparam dist_t c_id          = dist_t'(p_router_id);
    localparam cnt_t  c_cnt_last    = cnt_t'(p_slot_len - 1);
    localparam cnt_t  c_guard_start = cnt_t'(p_slot_len - p_guard);
    localparam dom_t  c_dom_last    = dom_t'(p_num_domains - 1);

`ifdef ROUTER_INPUT_CTRL_TDM_GUARD_EN
    localparam bit c_guard_en = 1'b1;
`else
    localparam bit c_guard_en = 1'b0;
`endif

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_t;

    state_t     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    dom_t       dom_q, dom_d;
    logic [2:0] lock_q, lock_d;

    dist_t      dest_x, de, dw;
    logic [2:0] route;
    logic [2:0] reqs;
    logic       accept;
    logic       cnt_wrap;
    logic       slot_ok;
    logic       dest_ok;
    logic       guard_block;
    logic       head_ok;

    assign cnt_wrap    = (cnt_q == c_cnt_last);
    assign slot_ok     = (io.in_domain == dom_q);
    assign dest_x      = {1'b0, io.dest};
    assign dest_ok     = (dest_x < c_n);
    assign guard_block = c_guard_en && (cnt_q >= c_guard_start);
    assign head_ok     = io.in_val && slot_ok && dest_ok && !guard_block;

    always_comb begin
        cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
        dom_d = dom_q;
        if (cnt_wrap) begin
            dom_d = (dom_q == c_dom_last) ? '0 : dom_q + 1'b1;
        end
    end

    // Eastward distance wraps through N; westward is its complement.
    always_comb begin
        de    = '0;
        route = '0;
        if (dest_x >= c_id) begin
            de = dest_x - c_id;
        end else begin
            de = dest_x + c_n - c_id;
        end
        dw = c_n - de;
        if (dest_x == c_id) begin
            route = 3'b010;
        end else if (de < dw) begin
            route = 3'b001;
        end else if (de > dw) begin
            route = 3'b100;
        end else begin
            route = p_tie_reqs;
        end
    end

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        reqs    = '0;
        accept  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (head_ok) begin
                    reqs = route;
                end
                accept = |(reqs & io.grants);
                if (accept && !io.in_tail) begin
                    state_d = S_LOCKED;
                    lock_d  = route;
                end
            end
            S_LOCKED: begin
                if (io.in_val && slot_ok) begin
                    reqs = lock_q;
                end
                accept = |(reqs & io.grants);
                if (accept && io.in_tail) begin
                    state_d = S_IDLE;
                    lock_d  = '0;
                end
            end
        endcase
        // Requests must vanish as soon as reset is raised, not at the next edge.
        if (reset) begin
            reqs   = '0;
            accept = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dom_q   <= '0;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dom_q   <= dom_d;
            lock_q  <= lock_d;
        end
    end

    assign io.reqs        = reqs;
    assign io.in_rdy      = accept;
    assign io.slot_domain = dom_q;
    assign io.locked      = (state_q == S_LOCKED);
    assign io.bad_dest    = io.in_val && (state_q == S_IDLE) && !dest_ok;

endmodule

// File: tb/tb_router_input_ctrl_tdm.sv
// Bench for router_input_ctrl_tdm: directed table, corner sequences and
// randomized traffic against a cycle-count based reference model.
module tb_router_input_ctrl_tdm;

    localparam int         N     = 8;
    localparam int         ID    = 2;
    localparam int         D     = 2;
    localparam int         SL    = 16;
    localparam int         GUARD = 4;
    localparam logic [2:0] TIE   = 3'b001;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   t;

    bit         m_locked;
    logic [2:0] m_route;
    logic [2:0] r;
    logic       rdy;

    typedef struct {
        int         d;
        int         dom;
        bit         tail;
        bit         val;
        logic [2:0] g;
        logic [2:0] er;
        bit         erdy;
    } vec_t;

    vec_t tbl[11];

    router_input_ctrl_tdm_if #(.c_dest_nbits(3), .c_dom_nbits(1)) ifa ();
    router_input_ctrl_tdm_if #(.c_dest_nbits(3), .c_dom_nbits(1)) ifb ();

    router_input_ctrl_tdm #(
        .p_router_id(ID), .p_num_routers(N), .p_num_domains(D),
        .p_slot_len(SL), .p_tie_reqs(TIE), .p_guard(GUARD)
    ) dut_a (
        .clk(clk), .reset(reset), .io(ifa.slave)
    );

    router_input_ctrl_tdm #(
        .p_router_id(2), .p_num_routers(6), .p_num_domains(2),
        .p_slot_len(16), .p_tie_reqs(3'b100), .p_guard(4)
    ) dut_b (
        .clk(clk), .reset(reset), .io(ifb.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) t <= 0;
        else       t <= t + 1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got %0h expected %0h", name, t, act, exp);
        end
    endtask

    function automatic logic [2:0] m_routef(int d);
        int de;
        int dw;
        if (d == ID) return 3'b010;
        de = ((d - ID) % N + N) % N;
        dw = N - de;
        if (de < dw) return 3'b001;
        if (de > dw) return 3'b100;
        return TIE;
    endfunction

    function automatic bit m_guard(int tt);
`ifdef ROUTER_INPUT_CTRL_TDM_GUARD_EN
        return (tt % SL) >= (SL - GUARD);
`else
        return (tt < 0);
`endif
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input int d, input int dom, input bit tail,
                        input bit val, input logic [2:0] g,
                        output logic [2:0] ro, output logic rdyo);
        logic [2:0] er;
        logic       erdy;
        bit         ok;
        int         sd;
        ifa.dest      = d[2:0];
        ifa.in_domain = dom[0:0];
        ifa.in_tail   = tail;
        ifa.in_val    = val;
        ifa.grants    = g;
        #1;
        sd = (t / SL) % D;
        ok = val && (dom == sd);
        er = 3'b000;
        if (!m_locked) begin
            if (ok && d < N && !m_guard(t)) er = m_routef(d);
        end else if (ok) begin
            er = m_route;
        end
        erdy = |(er & g);
        ro   = ifa.reqs;
        rdyo = ifa.in_rdy;
        chk("reqs", ifa.reqs, er);
        chk("in_rdy", ifa.in_rdy, erdy);
        chk("slot_domain", ifa.slot_domain, sd);
        chk("locked", ifa.locked, m_locked);
        chk("bad_dest", ifa.bad_dest, val && !m_locked && d >= N);
        if (erdy) begin
            if (!m_locked && !tail) begin
                m_locked = 1'b1;
                m_route  = er;
            end else if (m_locked && tail) begin
                m_locked = 1'b0;
                m_route  = 3'b000;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_reqs", ifa.reqs, 3'b000);
        chk("rst_rdy", ifa.in_rdy, 1'b0);
        chk("rst_locked", ifa.locked, 1'b0);
        chk("rst_slot", ifa.slot_domain, 1'b0);
        ifa.in_val = 1'b0;
        ifa.grants = 3'b000;
        ifa.in_tail = 1'b0;
        m_locked = 1'b0;
        m_route  = 3'b000;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int bd[6];
        logic [2:0] br[6];
        bit bb[6];

        ifa.dest = '0; ifa.in_domain = '0; ifa.in_tail = 1'b0;
        ifa.in_val = 1'b0; ifa.grants = '0;
        ifb.dest = '0; ifb.in_domain = '0; ifb.in_tail = 1'b1;
        ifb.in_val = 1'b0; ifb.grants = '0;

        tbl[0]  = '{2, 0, 1'b1, 1'b1, 3'b000, 3'b010, 1'b0};
        tbl[1]  = '{2, 0, 1'b1, 1'b1, 3'b010, 3'b010, 1'b1};
        tbl[2]  = '{5, 0, 1'b1, 1'b1, 3'b000, 3'b001, 1'b0};
        tbl[3]  = '{0, 0, 1'b1, 1'b1, 3'b100, 3'b100, 1'b1};
        tbl[4]  = '{6, 0, 1'b1, 1'b1, 3'b001, 3'b001, 1'b1};
        tbl[5]  = '{3, 0, 1'b1, 1'b1, 3'b100, 3'b001, 1'b0};
        tbl[6]  = '{1, 0, 1'b1, 1'b1, 3'b000, 3'b100, 1'b0};
        tbl[7]  = '{4, 0, 1'b1, 1'b1, 3'b001, 3'b001, 1'b1};
        tbl[8]  = '{5, 1, 1'b1, 1'b1, 3'b111, 3'b000, 1'b0};
        tbl[9]  = '{5, 0, 1'b1, 1'b0, 3'b111, 3'b000, 1'b0};
        tbl[10] = '{7, 0, 1'b0, 1'b1, 3'b000, 3'b100, 1'b0};

        #2;
        do_reset();

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].d, tbl[i].dom, tbl[i].tail, tbl[i].val, tbl[i].g,
                 r, rdy);
            chk("vec_reqs", r, tbl[i].er);
            chk("vec_rdy", rdy, tbl[i].erdy);
        end

        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(3, 1, 1'b1, 1'b1, 3'b111, r, rdy);
            chk("tdm_gate", r, 3'b000);
        end
        step(3, 1, 1'b1, 1'b1, 3'b111, r, rdy);
        chk("tdm_open_reqs", r, 3'b001);
        chk("tdm_open_rdy", rdy, 1'b1);
        chk("tdm_slot", ifa.slot_domain, 1'b1);

        do_reset();
        step(5, 0, 1'b0, 1'b1, 3'b001, r, rdy);
        chk("lock_head_rdy", rdy, 1'b1);
        step(2, 0, 1'b0, 1'b1, 3'b000, r, rdy);
        chk("lock_body_reqs", r, 3'b001);
        chk("lock_body_locked", ifa.locked, 1'b1);
        step(2, 0, 1'b0, 1'b1, 3'b001, r, rdy);
        step(2, 0, 1'b1, 1'b1, 3'b001, r, rdy);
        chk("lock_tail_rdy", rdy, 1'b1);
        chk("lock_released", ifa.locked, 1'b0);
        step(0, 0, 1'b0, 1'b0, 3'b000, r, rdy);

        do_reset();
        for (int i = 0; i < 5; i++) step(0, 0, 1'b0, 1'b0, 3'b000, r, rdy);
        step(5, 0, 1'b0, 1'b1, 3'b001, r, rdy);
        for (int i = 6; i < 16; i++) begin
            step(5, 0, 1'b0, 1'b1, 3'b000, r, rdy);
            chk("bnd_pre_reqs", r, 3'b001);
        end
        for (int i = 16; i < 32; i++) begin
            step(2, 0, 1'b0, 1'b1, 3'b001, r, rdy);
            chk("bnd_drop_reqs", r, 3'b000);
            chk("bnd_hold_lock", ifa.locked, 1'b1);
        end
        step(2, 0, 1'b0, 1'b1, 3'b001, r, rdy);
        chk("bnd_resume_reqs", r, 3'b001);
        do_reset();

        for (int i = 0; i < 12; i++) step(0, 0, 1'b0, 1'b0, 3'b000, r, rdy);
        for (int i = 12; i < 16; i++) begin
            step(5, 0, 1'b1, 1'b1, 3'b000, r, rdy);
`ifdef ROUTER_INPUT_CTRL_TDM_GUARD_EN
            chk("guard_block", r, 3'b000);
`else
            chk("no_guard_req", r, 3'b001);
`endif
        end
        for (int i = 16; i < 32; i++) step(5, 0, 1'b1, 1'b1, 3'b000, r, rdy);
        step(5, 0, 1'b1, 1'b1, 3'b001, r, rdy);
        chk("guard_next_slot", r, 3'b001);

        do_reset();
        bd = '{7, 6, 5, 0, 3, 2};
        br = '{3'b000, 3'b000, 3'b100, 3'b100, 3'b001, 3'b010};
        bb = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            ifb.dest      = bd[i][2:0];
            ifb.in_domain = 1'b0;
            ifb.in_val    = 1'b1;
            #1;
            chk("n6_bad_dest", ifb.bad_dest, bb[i]);
            chk("n6_reqs", ifb.reqs, br[i]);
            @(negedge clk);
        end
        ifb.in_val = 1'b0;

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int gi;
            logic [2:0] g;
            gi = $urandom_range(0, 3);
            g  = (gi == 0) ? 3'b000 : (3'b001 << (gi - 1));
            step($urandom_range(0, 7), $urandom_range(0, 1),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 4) != 0,
                 g, r, rdy);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/router_input_ctrl_tdm.md
Name: router_input_ctrl_tdm

Overview:
Next-generation ring-router input controller with timing-channel protection. It adds shortest-path direction selection on a ring of arbitrary size and multi-flit packet locking. It also time-multiplexes output requests by security domain, so an input only competes for outputs during its own domain's slot. One instance sits per router input port, between the input queue head and the three output-port arbiters.

Parameters:
- p_router_id, 0, ID of this router on the ring
- p_num_routers, 8, ring size N (any N ≥ 2, not restricted to a power of two)
- p_num_domains, 2, number of security domains D (≥ 1)
- p_slot_len, 16, cycles per TDM slot (≥ 2)
- p_tie_reqs, 3'b001, request vector used when east and west distances are equal
- p_guard, 4, guard-band length in cycles (used only with the optional feature; must be < p_slot_len)
- c_dest_nbits, $clog2(p_num_routers), destination width
- c_dom_nbits, max(1,$clog2(p_num_domains)), domain width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- dest  in  c_dest_nbits  destination router of the head-of-queue flit
- in_domain  in  c_dom_nbits  security domain of the head-of-queue flit
- in_tail  in  1  head-of-queue flit is the last flit of its packet (single-flit packet: head flit with in_tail=1)
- in_val  in  1  head-of-queue flit valid
- in_rdy  out  1  flit accepted this cycle
- reqs  out  3  output requests: bit0 east, bit1 terminal, bit2 west
- grants  in  3  grants from output arbiters (zero or one-hot)
- slot_domain  out  c_dom_nbits  domain that owns the current slot
- locked  out  1  a packet is mid-transfer (LOCKED state)
- bad_dest  out  1  a head flit with dest ≥ p_num_routers is presented

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, cycle counter=0, slot_domain=0, lock vector=000; reqs=000, in_rdy=0, locked=0.
- Slot timer:
  - The cycle counter counts 0..p_slot_len-1 and then wraps to 0.
  - On each wrap, slot_domain increments modulo D.
  - With D=1, slot_domain is always 0.
- Domain match: slot_ok = (in_domain == slot_domain). Domains ≥ D never match.
- Route computation (combinational, head flits only):
  - If dest==p_router_id, route=3'b010.
  - Otherwise compute de = (dest − p_router_id) mod N using c_dest_nbits+1-bit arithmetic (dest+N−id when dest<id), and dw = N − de.
  - de<dw gives 3'b001; de>dw gives 3'b100; de==dw gives p_tie_reqs.
- State IDLE:
  - reqs = route when in_val && slot_ok && dest<N; otherwise reqs=000.
  - in_rdy = |(reqs & grants).
  - An accepted flit with in_tail=0 moves to LOCKED and stores route in the lock vector.
  - An accepted flit with in_tail=1 stays in IDLE.
- State LOCKED:
  - reqs = lock vector when in_val && slot_ok; otherwise 000. dest is ignored.
  - in_rdy = |(reqs & grants).
  - An accepted tail flit returns the block to IDLE and clears the lock vector.
  - A body flit that is not accepted, or is outside its slot, stays LOCKED.
- bad_dest = in_val && state==IDLE && dest ≥ N. The flit is never requested, so software or the bench must drain it.
- Latency: zero-cycle combinational path from in_val/dest/grants to reqs/in_rdy. State and slot updates occur at the clock edge.
- Slot boundary mid-packet: requests drop at the boundary, the lock is kept, and requests resume in the domain's next slot.
- A grant on a bit not requested is ignored and has no state effect.
- Reset mid-packet: returns to IDLE immediately. The partial packet's remaining flits are then routed as heads, which is upstream's responsibility.

Optional Feature:
- Macro: ROUTER_INPUT_CTRL_TDM_GUARD_EN.
- Enabled:
  - In IDLE, head-flit requests are suppressed while cycle counter ≥ p_slot_len − p_guard.
  - LOCKED body/tail flits are unaffected.
  - This prevents a packet of any domain from starting late in a slot.
- Disabled: head flits may request on any cycle of their slot. p_guard is unused.

Test Plan:
- Setup for all scenarios: N=8, id=2, D=2, slot_len=16.
- Route, terminal: dest=2, domain 0, slot 0 → reqs=010. grants=010 → in_rdy=1.
- Route, shortest path: dest=5 gives de=3 → reqs=001. dest=0 gives de=6, dw=2 → reqs=100. dest=6 gives a tie → reqs=p_tie_reqs=001.
- TDM gating: domain-1 flit, dest=3, held valid from reset with grants=111 → reqs=000 for cycles 0–15; reqs=001 and in_rdy=1 at cycle 16; slot_domain=1.
- Packet lock: 3-flit packet, domain 0, dest=5, accepted head, then dest input changed to 2 → body reqs stay 001, locked=1. Tail accepted → locked=0 next cycle.
- Lock across boundary and reset: body flit pending at cycle 15→16 → reqs drop to 000 while locked=1 holds, resuming 001 at cycle 32. Asserting reset mid-packet → locked=0, reqs=000 immediately.
- Guard and bad destination (macro defined, p_guard=4): head, domain 0, at cycle 12 → reqs=000; same flit at cycle 32 → 001. dest=9 is not representable in 3 bits, so use N=6 with dest=7 → bad_dest=1, reqs=000.
